mem_responder: RTL and testbench

Memory-side responder for the processor's fetch/load/store bus. It accepts a request driven by an initiator: address from the MAR, a direction on `rw`, a strobe on `enable`, and write data from the MBR. It completes the access after a programmable number of wait states and signals completion on `mfc` (memory function complete). It sits between the MAR/MBR datapath and the on-chip memory array, and is the counterpart of the instruction-fetch and data-access control FSMs.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_array.sv | 30 +++
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for the processor memory bus: FSM encoding, bus direction and default widths.
// The fetch/load control FSMs import the same values.
package mem_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 16;
    localparam int DEPTH_DEF    = 256;
    localparam int WAIT_CYC_DEF = 2;
    localparam int CNT_W        = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W storage with synchronous write and registered read.
// The contents and the read register have no reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The read register only moves on a read, so it holds the last completed read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end else if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a MAR/MBR request, waits WAIT_CYC states, performs the
// access on the array and raises mfc until the initiator drops enable.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mfc,
    output logic              busy
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];
    localparam logic [CNT_W-1:0]  WAIT_LD   = WAIT_CYC[CNT_W-1:0];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mfc_q, mfc_d;
    logic              rzero_q, rzero_d;
    logic              access;
    logic              in_range;
    logic              arr_re, arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        mfc_d   = mfc_q;
        rzero_d = rzero_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mfc_d = 1'b0;
                if (enable) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    wdata_d = wdata;
                    cnt_d   = WAIT_LD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A dropped strobe beats completion, even on the counter==0 edge.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    access  = 1'b1;
                    mfc_d   = 1'b1;
                    state_d = ST_DONE;
                    if (rw_q == RW_READ) rzero_d = !in_range;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    mfc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mfc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= RW_READ;
            wdata_q <= '0;
            mfc_q   <= 1'b0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            mfc_q   <= mfc_d;
            rzero_q <= rzero_d;
        end
    end

    // Out-of-range accesses never touch the array; reads of them surface as zero via rzero_q.
    assign arr_re = access && (rw_q == RW_READ)  && in_range && reset;
    assign arr_we = access && (rw_q == RW_WRITE) && in_range && reset;

    mem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk  (clk),
        .re   (arr_re),
        .we   (arr_we),
        .idx  (addr_q[IDX_W-1:0]),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign rdata = rzero_q ? '0 : arr_rdata;
    assign mfc   = mfc_q;
    assign busy  = (state_q == ST_BUSY) || (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (WAIT_CYC=2, WAIT_CYC=0, DEPTH=128)
// share the bus inputs but each has its own enable strobe.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  en;
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  mfc, busy;
    logic [15:0] rdata [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYC(2)) u_w2 (
        .clk(clk), .reset(reset), .enable(en[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .mfc(mfc[0]), .busy(busy[0]));

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .reset(reset), .enable(en[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .mfc(mfc[1]), .busy(busy[1]));

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_CYC(2)) u_d128 (
        .clk(clk), .reset(reset), .enable(en[2]), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata[2]), .mfc(mfc[2]), .busy(busy[2]));

    // Drives one request, scrambles the bus once accepted, and waits (bounded) for mfc.
    // lat = edges after the accept edge at which mfc was first seen, -1 on timeout.
    task automatic request(input int d, input logic r, input logic [7:0] a, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd, output logic bsy_e,
                           output time t_acc);
        @(negedge clk);
        rw = r; addr = a; wdata = wd; en[d] = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        bsy_e = busy[d];
        lat = mfc[d] ? 0 : -1;
        @(negedge clk);
        rw = ~r; addr = ~a; wdata = ~wd;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (mfc[d]) lat = i;
        end
        rd = rdata[d];
    endtask

    task automatic release_req(input int d);
        @(negedge clk);
        en[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = '0; rw = 1'b1; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if ({mfc[d], busy[d], rdata[d]} !== 18'h0) begin
                    n_bad++;
                    $display("FAIL reset_idle inst %0d cyc %0d: mfc=%b busy=%b rdata=%h, want 0/0/0000",
                             d, c, mfc[d], busy[d], rdata[d]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd, e; logic b; time t;
        request(0, 1'b0, 8'h10, 16'hBEEF, lat, rd, b, t);
        n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL wr_busy got %b want 1", b); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_lat got %0d want 3", lat); end
        n_cmp++; if (rd !== 16'h0) begin n_bad++; $display("FAIL wr_rdata_hold got %h want 0000", rd); end
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL done_busy got %b want 1", busy[0]); end
        release_req(0);
        n_cmp++; if ({mfc[0], busy[0]} !== 2'b00) begin
            n_bad++; $display("FAIL wr_release got mfc=%b busy=%b want 0/0", mfc[0], busy[0]);
        end
        exp_q.push_back(16'hBEEF);
        request(0, 1'b1, 8'h10, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_lat got %0d want 3", lat); end
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL rd_data got %h want %h", rd, e); end
        release_req(0);
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd, e; logic b; time t1, t2;
        request(1, 1'b0, 8'h00, 16'h1111, lat, rd, b, t1); release_req(1);
        request(1, 1'b0, 8'h01, 16'h2222, lat, rd, b, t1); release_req(1);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        request(1, 1'b1, 8'h00, 16'h0, lat, rd, b, t1);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_lat0 got %0d want 1", lat); end
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL b2b_data0 got %h want %h", rd, e); end
        release_req(1);
        request(1, 1'b1, 8'h01, 16'h0, lat, rd, b, t2);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_lat1 got %0d want 1", lat); end
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL b2b_data1 got %h want %h", rd, e); end
        n_cmp++; if ((t2 - t1) !== 30) begin
            n_bad++; $display("FAIL b2b_spacing got %0t want 30", t2 - t1);
        end
        release_req(1);
    endtask

    task automatic test_abort();
        int lat; logic [15:0] rd, e; logic b, seen; time t;
        request(0, 1'b0, 8'h20, 16'hAAAA, lat, rd, b, t); release_req(0);
        // Abort one cycle into BUSY.
        @(negedge clk); rw = 1'b0; addr = 8'h20; wdata = 16'h5555; en[0] = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL abort_busy got %b want 1", busy[0]); end
        @(posedge clk);
        @(negedge clk); en[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; seen |= mfc[0]; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_mfc got %b want 0", seen); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %b want 0", busy[0]); end
        exp_q.push_back(16'hAAAA);
        request(0, 1'b1, 8'h20, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL abort_keep got %h want %h", rd, e); end
        release_req(0);
        // WAIT_CYC=0: strobe drops exactly on the completion edge.
        @(negedge clk); rw = 1'b0; addr = 8'h01; wdata = 16'h5555; en[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); en[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; seen |= mfc[1]; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_edge_mfc got %b want 0", seen); end
        exp_q.push_back(16'h2222);
        request(1, 1'b1, 8'h01, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL abort_edge_keep got %h want %h", rd, e); end
        release_req(1);
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd, e; logic b; time t;
        request(2, 1'b0, 8'h70, 16'h7777, lat, rd, b, t); release_req(2);
        request(2, 1'b0, 8'hF0, 16'h1234, lat, rd, b, t);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_wr_lat got %0d want 3", lat); end
        release_req(2);
        exp_q.push_back(16'h7777);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h7777);
        request(2, 1'b1, 8'h70, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oor_pre got %h want %h", rd, e); end
        release_req(2);
        request(2, 1'b1, 8'hF0, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_rd_lat got %0d want 3", lat); end
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oor_rd_zero got %h want %h", rd, e); end
        release_req(2);
        request(2, 1'b1, 8'h70, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL oor_alias got %h want %h", rd, e); end
        release_req(2);
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd, e; logic b; time t;
        @(negedge clk); rw = 1'b0; addr = 8'h10; wdata = 16'hDEAD; en[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0; en[0] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({mfc[0], busy[0], rdata[0]} !== 18'h0) begin
            n_bad++; $display("FAIL mid_reset got mfc=%b busy=%b rdata=%h want 0/0/0000",
                              mfc[0], busy[0], rdata[0]);
        end
        @(negedge clk); reset = 1'b1;
        exp_q.push_back(16'hBEEF);
        request(0, 1'b1, 8'h10, 16'h0, lat, rd, b, t);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mid_after_lat got %0d want 3", lat); end
        n_cmp++; if (rd !== e) begin n_bad++; $display("FAIL mid_keep got %h want %h", rd, e); end
        release_req(0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
